// File: rtl/poly_voice_engine.sv
// Polyphonic voice engine: NUM_VOICES phase-accumulator voices mixed once per sample tick.
// Define POLY_VOICE_STEAL_EN to steal a busy voice round-robin instead of dropping the note-on.
module pve_voice #(
    parameter int PHASE_W  = 24,
    parameter int INC_BASE = 1398
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               trig,
    input  logic               off,
    input  logic               adv,
    input  logic [4:0]         note_in,
    output logic               active,
    output logic [4:0]         note,
    output logic [PHASE_W-1:0] phase_nxt
);
    logic [PHASE_W-1:0] phase;

    // INC_BASE*(note+1), folded so no extra multiplier bit is needed
    assign phase_nxt = phase + PHASE_W'(INC_BASE) * PHASE_W'(note) + PHASE_W'(INC_BASE);

    always_ff @(posedge clk) begin
        if (reset) begin
            active <= 1'b0;
            note   <= '0;
            phase  <= '0;
        end else if (trig) begin
            active <= 1'b1;
            note   <= note_in;
            phase  <= '0;
        end else begin
            if (off) active <= 1'b0;
            if (adv) phase  <= phase_nxt;
        end
    end
endmodule

module poly_voice_engine #(
    parameter int NUM_VOICES = 4,
    parameter int PHASE_W    = 24,
    parameter int SAMPLE_W   = 32,
    parameter int CLK_DIV    = 1042,
    parameter int INC_BASE   = 1398
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  note_valid,
    input  logic                  note_on,
    input  logic [4:0]            note,
    input  logic [1:0]            wave_sel,
    input  logic                  out_ready,
    output logic [SAMPLE_W-1:0]   out_sample,
    output logic                  out_valid,
    output logic [NUM_VOICES-1:0] active_mask,
    output logic                  overflow,
    output logic                  late
);
    localparam int L     = $clog2(NUM_VOICES);
    localparam int ACC_W = 16 + L;
    localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, PRESENT} state_t;

    state_t                             state;
    logic [CNT_W-1:0]                   cnt;
    logic                               tick;
    logic [L-1:0]                       idx;
    logic [ACC_W-1:0]                   acc, acc_sum;
    logic [NUM_VOICES-1:0]              act, hit, trig, off, adv;
    logic [NUM_VOICES-1:0][4:0]         vnote;
    logic [NUM_VOICES-1:0][PHASE_W-1:0] ph_nxt;
    logic [L-1:0]                       free_idx;
    logic                               free_found, ovf_nxt;
    logic [15:0]                        p, wave, tri_u;
    logic [SAMPLE_W-1:0]                aligned;
`ifdef POLY_VOICE_STEAL_EN
    logic [L-1:0]                       steal_ptr;
    logic                               steal_adv;
`endif

    assign tick        = (cnt == CNT_W'(CLK_DIV - 1));
    assign active_mask = act;

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
        assign hit[g] = act[g] && (vnote[g] == note);
        assign adv[g] = (state == ACCUM) && (idx == L'(g)) && act[g];
        pve_voice #(.PHASE_W(PHASE_W), .INC_BASE(INC_BASE)) u_voice (
            .clk      (CLOCK_50),
            .reset    (reset),
            .trig     (trig[g]),
            .off      (off[g]),
            .adv      (adv[g]),
            .note_in  (note),
            .active   (act[g]),
            .note     (vnote[g]),
            .phase_nxt(ph_nxt[g])
        );
    end

    // Note allocation: retrigger a holder first, else lowest free voice, else steal/drop
    always_comb begin
        trig       = '0;
        off        = '0;
        ovf_nxt    = 1'b0;
        free_found = 1'b0;
        free_idx   = '0;
`ifdef POLY_VOICE_STEAL_EN
        steal_adv  = 1'b0;
`endif
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (!act[i]) begin
                free_found = 1'b1;
                free_idx   = L'(i);
            end
        end
        if (note_valid) begin
            if (!note_on) begin
                off = hit;
            end else if (|hit) begin
                trig = hit;
            end else if (free_found) begin
                trig[free_idx] = 1'b1;
            end else begin
`ifdef POLY_VOICE_STEAL_EN
                trig[steal_ptr] = 1'b1;
                steal_adv       = 1'b1;
`else
                ovf_nxt = 1'b1;
`endif
            end
        end
    end

    // Waveform of the voice being visited, taken from its freshly advanced phase
    always_comb begin
        p     = ph_nxt[idx][PHASE_W-1 -: 16];
        tri_u = p[15] ? ~{p[14:0], 1'b0} : {p[14:0], 1'b0};
        wave  = '0;
        if (act[idx]) begin
            case (wave_sel)
                2'b00:   wave = p[15] ? 16'hC001 : 16'h3FFF;
                2'b01:   wave = {~p[15], p[14:0]};
                2'b10:   wave = {~tri_u[15], tri_u[14:0]};
                default: wave = '0;
            endcase
        end
        acc_sum = acc + {{L{wave[15]}}, wave};
        aligned = '0;
        aligned[SAMPLE_W-1 -: 16] = acc_sum[ACC_W-1 -: 16];
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= '0;
            acc        <= '0;
            out_sample <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            late       <= 1'b0;
        end else begin
            cnt      <= tick ? '0 : cnt + 1'b1;
            overflow <= ovf_nxt;
            late     <= tick && (state != IDLE);
            case (state)
                IDLE: if (tick) begin
                    state <= ACCUM;
                    idx   <= '0;
                    acc   <= '0;
                end
                ACCUM: begin
                    acc <= acc_sum;
                    idx <= idx + 1'b1;
                    if (idx == L'(NUM_VOICES - 1)) begin
                        state      <= PRESENT;
                        out_sample <= aligned;
                        out_valid  <= 1'b1;
                    end
                end
                PRESENT: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef POLY_VOICE_STEAL_EN
    always_ff @(posedge CLOCK_50) begin
        if (reset)          steal_ptr <= '0;
        else if (steal_adv) steal_ptr <= steal_ptr + 1'b1;
    end
`endif
endmodule

// File: tb/tb_poly_voice_engine.sv
// Directed bench for poly_voice_engine: 4 voices, short sample period, hand-computed samples.
module tb_poly_voice_engine;
    logic        CLOCK_50 = 1'b0;
    logic        reset = 1'b1;
    logic        note_valid = 1'b0;
    logic        note_on = 1'b0;
    logic [4:0]  note = '0;
    logic [1:0]  wave_sel = '0;
    logic        out_ready = 1'b1;
    logic [31:0] out_sample;
    logic        out_valid;
    logic [3:0]  active_mask;
    logic        overflow;
    logic        late;

    int checks = 0;
    int errors = 0;

    poly_voice_engine #(
        .NUM_VOICES(4), .PHASE_W(24), .SAMPLE_W(32), .CLK_DIV(32), .INC_BASE(1398)
    ) dut (
        .CLOCK_50   (CLOCK_50),
        .reset      (reset),
        .note_valid (note_valid),
        .note_on    (note_on),
        .note       (note),
        .wave_sel   (wave_sel),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .out_valid  (out_valid),
        .active_mask(active_mask),
        .overflow   (overflow),
        .late       (late)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        note_valid = 1'b0;
        step();
        step();
        chk("rst_valid",  {31'd0, out_valid}, 32'd0);
        chk("rst_sample", out_sample, 32'd0);
        chk("rst_mask",   {28'd0, active_mask}, 32'd0);
        chk("rst_ovf",    {31'd0, overflow}, 32'd0);
        chk("rst_late",   {31'd0, late}, 32'd0);
        reset = 1'b0;
    endtask

    task automatic send(input logic on, input logic [4:0] n);
        note_valid = 1'b1;
        note_on = on;
        note = n;
        step();
        note_valid = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!out_valid && n < 200) begin
            step();
            n++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    initial begin
        int late_cnt;
        int unstable;
        int vcount;
        logic [31:0] s0;

        do_reset();

        // Silence: three samples of zero with nothing held
        for (int k = 0; k < 3; k++) begin
            wait_valid("idle_wait");
            chk("idle_sample", out_sample, 32'd0);
            chk("idle_mask", {28'd0, active_mask}, 32'd0);
            step();
            chk("idle_handshake", {31'd0, out_valid}, 32'd0);
        end

        // One voice, note 5: inc 8388 per sample, each waveform type in turn
        do_reset();
        wave_sel = 2'b00;
        send(1'b1, 5'd5);
        chk("on5_mask", {28'd0, active_mask}, 32'h1);
        send(1'b1, 5'd5);
        chk("on5_retrig_mask", {28'd0, active_mask}, 32'h1);
        chk("on5_no_ovf", {31'd0, overflow}, 32'd0);
        wait_valid("sq_wait");
        chk("square_s1", out_sample, 32'h0FFF_0000);
        step();
        wave_sel = 2'b01;
        wait_valid("saw_wait");
        chk("saw_s2", out_sample, 32'hE010_0000);
        step();
        wave_sel = 2'b10;
        wait_valid("tri_wait");
        chk("tri_s3", out_sample, 32'hE031_0000);
        step();
        wave_sel = 2'b11;
        wait_valid("mute_wait");
        chk("mute_s4", out_sample, 32'd0);
        step();
        wave_sel = 2'b01;
        send(1'b1, 5'd5);
        chk("retrig_mask", {28'd0, active_mask}, 32'h1);
        wait_valid("retrig_wait");
        chk("retrig_saw", out_sample, 32'hE008_0000);
        step();

        // Full allocation then one more note-on
        do_reset();
        wave_sel = 2'b00;
        send(1'b1, 5'd1);
        send(1'b1, 5'd2);
        send(1'b1, 5'd3);
        send(1'b1, 5'd4);
        chk("full_mask", {28'd0, active_mask}, 32'hF);
        send(1'b1, 5'd7);
        chk("extra_mask", {28'd0, active_mask}, 32'hF);
`ifdef POLY_VOICE_STEAL_EN
        chk("extra_ovf", {31'd0, overflow}, 32'd0);
`else
        chk("extra_ovf", {31'd0, overflow}, 32'd1);
`endif
        step();
        chk("ovf_pulse_end", {31'd0, overflow}, 32'd0);
        wait_valid("mix_wait");
        chk("mix4_square", out_sample, 32'h3FFF_0000);
        step();
        send(1'b0, 5'd1);
`ifdef POLY_VOICE_STEAL_EN
        chk("off1_mask", {28'd0, active_mask}, 32'hF);
`else
        chk("off1_mask", {28'd0, active_mask}, 32'hE);
`endif
        send(1'b0, 5'd7);
        chk("off7_mask", {28'd0, active_mask}, 32'hE);

        // Note-off, then a repeated note-off for the released note
        do_reset();
        send(1'b1, 5'd9);
        chk("on9_mask", {28'd0, active_mask}, 32'h1);
        send(1'b0, 5'd9);
        chk("off9_mask", {28'd0, active_mask}, 32'h0);
        send(1'b0, 5'd9);
        chk("off9_again_mask", {28'd0, active_mask}, 32'h0);
        chk("off9_no_ovf", {31'd0, overflow}, 32'd0);

        // Backpressure across two ticks
        do_reset();
        wave_sel = 2'b00;
        out_ready = 1'b0;
        send(1'b1, 5'd5);
        wait_valid("bp_wait");
        s0 = out_sample;
        chk("bp_sample", s0, 32'h0FFF_0000);
        late_cnt = 0;
        unstable = 0;
        repeat (66) begin
            step();
            if (late) late_cnt++;
            if (!out_valid || out_sample !== s0) unstable++;
        end
        chk("bp_late_count", late_cnt, 32'd2);
        chk("bp_hold", unstable, 32'd0);
        out_ready = 1'b1;
        step();
        chk("bp_handshake", {31'd0, out_valid}, 32'd0);
        vcount = 0;
        repeat (10) begin
            step();
            if (out_valid) vcount++;
        end
        chk("bp_single", vcount, 32'd0);

        // Reset while a sample is pending
        out_ready = 1'b0;
        wait_valid("rp_wait");
        reset = 1'b1;
        step();
        chk("rp_valid",  {31'd0, out_valid}, 32'd0);
        chk("rp_mask",   {28'd0, active_mask}, 32'd0);
        chk("rp_sample", out_sample, 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/poly_voice_engine.md
POLY_VOICE_ENGINE -- requirements
Module: poly_voice_engine

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, number of simultaneous voices (power of two, 2..16).
REQ-002 SHALL have parameter PHASE_W, default 24, phase accumulator width.
REQ-003 SHALL have parameter SAMPLE_W, default 32, output sample width (>=16).
REQ-004 SHALL have parameter CLK_DIV, default 1042, clocks per sample tick.
REQ-005 SHALL have parameter INC_BASE, default 1398, per-note phase increment unit.
REQ-006 SHALL have port CLOCK_50  input  1  sole clock; reset is synchronous and active-high.
REQ-007 SHALL have port reset  input  1  synchronous active-high reset.
REQ-008 SHALL have port note_valid  input  1  one-cycle note event strobe, always accepted.
REQ-009 SHALL have port note_on  input  1  1 = note-on, 0 = note-off; qualified by note_valid.
REQ-010 SHALL have port note  input  5  note number 0..31.
REQ-011 SHALL have port wave_sel  input  2  00 square, 01 saw, 10 triangle, 11 mute.
REQ-012 SHALL have port out_ready  input  1  sink accepts sample (audio_out_allowed).
REQ-013 SHALL have port out_sample  output  SAMPLE_W  mixed signed sample, same value for left and right.
REQ-014 SHALL have port out_valid  output  1  out_sample valid.
REQ-015 SHALL have port active_mask  output  NUM_VOICES  bit i = voice i busy.
REQ-016 SHALL have port overflow  output  1  one-cycle pulse: note-on not placed.
REQ-017 SHALL have port late  output  1  one-cycle pulse: tick arrived while sample unaccepted.

Function
REQ-018 SHALL count 0..CLK_DIV-1 and raise an internal tick when count wraps to 0.
REQ-019 SHALL run FSM IDLE -> ACCUM -> PRESENT -> IDLE; IDLE leaves on tick.
REQ-020 ACCUM SHALL visit one voice per cycle, index 0..NUM_VOICES-1, then enter PRESENT (NUM_VOICES cycles).
REQ-021 Per visited active voice: phase += INC_BASE*(note+1) mod 2^PHASE_W, then its waveform value is added to the accumulator; inactive voices add 0 and hold phase.
REQ-022 Waveform from p = phase[PHASE_W-1 -: 16]: square = p[15] ? -16'sh3FFF : +16'sh3FFF; saw = {~p[15], p[14:0]} signed; triangle = fold of p to signed 16 bits; mute = 0.
REQ-023 Accumulator SHALL be 16+log2(NUM_VOICES) bits signed; result arithmetically shifted right log2(NUM_VOICES), then left-aligned into SAMPLE_W (low bits zero).
REQ-024 PRESENT SHALL assert out_valid with out_sample stable until out_valid&&out_ready, then return to IDLE next cycle.
REQ-025 A tick during ACCUM or PRESENT SHALL be dropped and pulse late; the pending sample is kept.
REQ-026 Note-on for a note already held by a voice SHALL retrigger it (phase := 0), not allocate.
REQ-027 Otherwise note-on SHALL allocate the lowest-index free voice, phase := 0, active := 1.
REQ-028 Note-off SHALL clear active on every voice holding that note; note-off for an unheld note is ignored.
REQ-029 Note events during ACCUM SHALL take effect at the next cycle; a voice already visited this sample is not re-visited.
REQ-030 active_mask SHALL reflect allocation changes one cycle after note_valid.

Reset
REQ-031 On reset all voices inactive, phases 0, tick counter 0, FSM IDLE, steal pointer 0.
REQ-032 Outputs during/after reset: out_sample 0, out_valid 0, active_mask 0, overflow 0, late 0; reset in PRESENT drops the pending sample.

Configuration
REQ-033 Macro POLY_VOICE_STEAL_EN defined: note-on with all voices busy SHALL take the voice at a round-robin steal pointer (then pointer+1 mod NUM_VOICES) and SHALL NOT pulse overflow.
REQ-034 Macro undefined: such note-on SHALL be discarded and overflow pulses one cycle; no steal pointer logic exists.

Verification
REQ-035 Reset, then idle 3 ticks with out_ready=1 -> three samples of 0, active_mask=0.
REQ-036 NUM_VOICES=4, square, note-on 5 then note-on 5 -> active_mask=0001, voice 0 phase zeroed twice; first sample = 16'sh3FFF>>>2 left-aligned.
REQ-037 Note-on 1,2,3,4,7 with steal macro -> mask 1111, voice 0 holds 7; without macro -> overflow pulse, voice 0 still holds 1.
REQ-038 Note-on 9 on voices 0 and, after note-off 9, note-off 9 again -> mask 0001 then 0000, second note-off no effect.
REQ-039 Hold out_ready=0 across 2 ticks -> out_valid stays 1, out_sample unchanged, late pulses twice; raise out_ready -> single handshake.
REQ-040 Assert reset while in PRESENT -> next cycle out_valid=0, active_mask=0.
